// File: rtl/pe_dbuf_ws_os.sv
// Systolic PE with shadow/active weight double buffer (WS), local accumulator
// with partial-sum drain chain (OS), optional multiplier stage and saturating sums.
module pe_dbuf_ws_os #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int MULT_PIPE  = 1,
    parameter int SATURATE   = 1
) (
    input  logic                         CLK,
    input  logic                         SYNC_RST,
    input  logic                         EN,
    input  logic                         MODE,
    input  logic                         LOAD,
    input  logic                         SWAP,
    input  logic                         FLUSH,
    input  logic                         DRAIN,
    input  logic signed [DATA_WIDTH-1:0] Input,
    input  logic signed [DATA_WIDTH-1:0] WeightIn,
    input  logic signed [ACC_WIDTH-1:0]  PsumIn,
    output logic signed [DATA_WIDTH-1:0] ToRight,
    output logic signed [DATA_WIDTH-1:0] WeightDown,
    output logic signed [ACC_WIDTH-1:0]  PsumOut,
    output logic                         ValidOut,
    output logic                         OVF
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] shadow_reg, shadow_next;
    logic signed [DATA_WIDTH-1:0] active_reg, active_next;
    logic signed [DATA_WIDTH-1:0] to_right_reg, to_right_next;
    logic signed [DATA_WIDTH-1:0] weight_down_os_reg, weight_down_os_next;
    logic signed [ACC_WIDTH-1:0]  psum_out_reg, psum_out_next;
    logic signed [ACC_WIDTH-1:0]  acc_reg, acc_next;
    logic                         valid_out_reg, valid_out_next;
    logic                         ovf_reg, ovf_next;

    logic signed [DATA_WIDTH-1:0] operand;
    logic signed [PW-1:0]         product;
    logic signed [SW-1:0]         product_ext;
    logic signed [SW-1:0]         commit_prod;
    logic signed [ACC_WIDTH-1:0]  commit_psum;
    logic                         commit_vld;

    assign operand     = MODE ? WeightIn : active_reg;
    assign product     = Input * operand;
    assign product_ext = {{(SW-PW){product[PW-1]}}, product};

    // Stage 1 advances every cycle; a cycle without EN travels as a bubble.
    generate
        if (MULT_PIPE != 0) begin : g_pipe
            logic signed [SW-1:0]        prod_s1_reg;
            logic signed [ACC_WIDTH-1:0] psum_s1_reg;
            logic                        vld_s1_reg;

            always_ff @(posedge CLK) begin
                if (SYNC_RST) begin
                    prod_s1_reg <= '0;
                    psum_s1_reg <= '0;
                    vld_s1_reg  <= 1'b0;
                end else begin
                    prod_s1_reg <= product_ext;
                    psum_s1_reg <= PsumIn;
                    vld_s1_reg  <= EN;
                end
            end

            assign commit_prod = prod_s1_reg;
            assign commit_psum = psum_s1_reg;
            assign commit_vld  = vld_s1_reg;
        end else begin : g_comb
            assign commit_prod = product_ext;
            assign commit_psum = PsumIn;
            assign commit_vld  = EN;
        end
    endgenerate

    function automatic logic sum_ovf(input logic signed [SW-1:0] s);
        return s[SW-1] ^ s[SW-2];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sum_fix(input logic signed [SW-1:0] s);
        if ((SATURATE != 0) && sum_ovf(s))
            return s[SW-1] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    logic signed [SW-1:0]        ws_wide, os_wide;
    logic signed [ACC_WIDTH-1:0] os_acc;

    assign ws_wide = commit_prod + {commit_psum[ACC_WIDTH-1], commit_psum};
    assign os_wide = commit_prod + {acc_reg[ACC_WIDTH-1], acc_reg};
    assign os_acc  = commit_vld ? sum_fix(os_wide) : acc_reg;

    always_comb begin
        shadow_next         = shadow_reg;
        active_next         = active_reg;
        to_right_next       = to_right_reg;
        weight_down_os_next = weight_down_os_reg;
        psum_out_next       = psum_out_reg;
        acc_next            = acc_reg;
        valid_out_next      = 1'b0;
        ovf_next            = ovf_reg;

        if (EN)
            to_right_next = Input;

        if (!MODE) begin
            if (LOAD)
                shadow_next = WeightIn;
            // SWAP reads the pre-load shadow, so LOAD+SWAP behaves as a shift.
            if (SWAP)
                active_next = shadow_reg;
            if (commit_vld) begin
                psum_out_next  = sum_fix(ws_wide);
                valid_out_next = 1'b1;
                if (sum_ovf(ws_wide))
                    ovf_next = 1'b1;
            end
        end else begin
            if (EN)
                weight_down_os_next = WeightIn;
            if (commit_vld && sum_ovf(os_wide))
                ovf_next = 1'b1;
            acc_next = os_acc;
            if (FLUSH) begin
                psum_out_next = os_acc;
                acc_next      = '0;
            end else if (DRAIN) begin
                psum_out_next = PsumIn;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            shadow_reg         <= '0;
            active_reg         <= '0;
            to_right_reg       <= '0;
            weight_down_os_reg <= '0;
            psum_out_reg       <= '0;
            acc_reg            <= '0;
            valid_out_reg      <= 1'b0;
            ovf_reg            <= 1'b0;
        end else begin
            shadow_reg         <= shadow_next;
            active_reg         <= active_next;
            to_right_reg       <= to_right_next;
            weight_down_os_reg <= weight_down_os_next;
            psum_out_reg       <= psum_out_next;
            acc_reg            <= acc_next;
            valid_out_reg      <= valid_out_next;
            ovf_reg            <= ovf_next;
        end
    end

    assign ToRight    = to_right_reg;
    assign WeightDown = MODE ? weight_down_os_reg : shadow_reg;
    assign PsumOut    = psum_out_reg;
    assign ValidOut   = valid_out_reg;
    assign OVF        = ovf_reg;

endmodule

// File: tb/tb_pe_dbuf_ws_os.sv
// Scoreboarded bench for pe_dbuf_ws_os (DATA_WIDTH=8, ACC_WIDTH=32, MULT_PIPE=1, SATURATE=1).
module tb_pe_dbuf_ws_os;

    logic              CLK = 1'b0;
    logic              SYNC_RST, EN, MODE, LOAD, SWAP, FLUSH, DRAIN;
    logic signed [7:0]  Input, WeightIn;
    logic signed [31:0] PsumIn;
    logic signed [7:0]  ToRight, WeightDown;
    logic signed [31:0] PsumOut;
    logic              ValidOut, OVF;

    int     vectors     = 0;
    int     miscompares = 0;
    longint sb_q[$];

    always #5 CLK = ~CLK;

    pe_dbuf_ws_os #(
        .DATA_WIDTH(8), .ACC_WIDTH(32), .MULT_PIPE(1), .SATURATE(1)
    ) dut (
        .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .SWAP(SWAP), .FLUSH(FLUSH), .DRAIN(DRAIN), .Input(Input),
        .WeightIn(WeightIn), .PsumIn(PsumIn), .ToRight(ToRight),
        .WeightDown(WeightDown), .PsumOut(PsumOut), .ValidOut(ValidOut), .OVF(OVF)
    );

    task automatic check_value(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic longint ws_exp(input longint a, input longint w, input longint p);
        longint s;
        s = a * w + p;
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        SYNC_RST = 1'b0; EN = 1'b0; LOAD = 1'b0; SWAP = 1'b0; FLUSH = 1'b0; DRAIN = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_to_right"}, ToRight, 0);
        check_value({tag, "_weight_down"}, WeightDown, 0);
        check_value({tag, "_psum_out"}, PsumOut, 0);
        check_value({tag, "_valid_out"}, ValidOut, 0);
        check_value({tag, "_ovf"}, OVF, 0);
    endtask

    // Every ValidOut pulse must match the oldest outstanding WS issue.
    always @(negedge CLK) begin
        if (ValidOut === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_value("valid_spurious", 1, 0);
            end else begin
                longint e;
                e = sb_q.pop_front();
                check_value("ws_psum", PsumOut, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        SYNC_RST = 1'b1; EN = 1'b0; MODE = 1'b0; LOAD = 1'b0; SWAP = 1'b0;
        FLUSH = 1'b0; DRAIN = 1'b0; Input = '0; WeightIn = '0; PsumIn = '0;
        #1;
        SYNC_RST = 1'b1; step();
        check_all_zero("rst_init");

        // Dirty every register, then reset with a product in flight.
        LOAD = 1'b1; WeightIn = 8'sd5; step();
        SWAP = 1'b1; step();
        EN = 1'b1; Input = 8'sd3; PsumIn = 32'sd7; sb_q.push_back(ws_exp(3, 5, 7)); step();
        step();
        LOAD = 1'b1; WeightIn = 8'sd6; EN = 1'b1; Input = 8'sd2; PsumIn = 32'sd1; step();
        SYNC_RST = 1'b1; step();
        check_all_zero("rst_dirty");
        step();
        check_value("rst_inflight_valid", ValidOut, 0);
        EN = 1'b1; Input = 8'sd5; PsumIn = 32'sd1; sb_q.push_back(ws_exp(5, 0, 1)); step();
        step(); step();

        // WS basic latency.
        LOAD = 1'b1; WeightIn = -8'sd3; step();
        SWAP = 1'b1; step();
        EN = 1'b1; Input = 8'sd5; PsumIn = 32'sd100; sb_q.push_back(85); step();
        check_value("ws_to_right", ToRight, 5);
        check_value("ws_valid_early", ValidOut, 0);
        step();
        check_value("ws_valid_lat2", ValidOut, 1);
        check_value("ws_psum_85", PsumOut, 85);
        step();

        // Double buffer: load during compute, then swap.
        LOAD = 1'b1; WeightIn = 8'sd2; step();
        SWAP = 1'b1; step();
        LOAD = 1'b1; WeightIn = 8'sd7; EN = 1'b1; Input = 8'sd4; PsumIn = 32'sd0;
        sb_q.push_back(8); step();
        check_value("dbuf_weight_down", WeightDown, 7);
        SWAP = 1'b1; step();
        EN = 1'b1; Input = 8'sd4; PsumIn = 32'sd0; sb_q.push_back(28); step();
        step(); step();

        // LOAD and SWAP together.
        LOAD = 1'b1; WeightIn = 8'sd9; step();
        LOAD = 1'b1; SWAP = 1'b1; WeightIn = 8'sd6; step();
        check_value("ldsw_weight_down", WeightDown, 6);
        EN = 1'b1; Input = 8'sd1; PsumIn = 32'sd0; sb_q.push_back(9); step();
        SWAP = 1'b1; step();
        EN = 1'b1; Input = 8'sd1; PsumIn = 32'sd0; sb_q.push_back(6); step();
        step(); step();

        // Back-to-back random issues with active weight 6.
        for (int i = 0; i < 6; i++) begin
            EN = 1'b1;
            Input = 8'($urandom_range(0, 255));
            PsumIn = 32'($urandom_range(0, 200000)) - 32'sd100000;
            sb_q.push_back(ws_exp(longint'(Input), 6, longint'(PsumIn)));
            step();
        end
        step(); step();

        // Saturation and sticky OVF.
        LOAD = 1'b1; WeightIn = 8'sd127; step();
        SWAP = 1'b1; step();
        EN = 1'b1; Input = 8'sd127; PsumIn = 32'sh7FFFFFF0; sb_q.push_back(64'sh7FFFFFFF); step();
        step();
        check_value("sat_ovf_set", OVF, 1);
        EN = 1'b1; Input = -8'sd128; PsumIn = 32'sh80000000; sb_q.push_back(-64'sd2147483648); step();
        EN = 1'b1; Input = 8'sd1; PsumIn = 32'sd0; sb_q.push_back(127); step();
        step(); step();
        check_value("sat_ovf_sticky", OVF, 1);
        SYNC_RST = 1'b1; step();
        check_value("sat_ovf_cleared", OVF, 0);

        // OS mode: accumulate, flush, drain.
        MODE = 1'b1; SYNC_RST = 1'b1; step();
        EN = 1'b1; Input = 8'sd2;  WeightIn = 8'sd3; step();
        EN = 1'b1; Input = -8'sd4; WeightIn = 8'sd5; step();
        EN = 1'b1; Input = 8'sd7;  WeightIn = 8'sd1; step();
        FLUSH = 1'b1; step();
        check_value("os_flush", PsumOut, -7);
        check_value("os_valid", ValidOut, 0);
        check_value("os_to_right", ToRight, 7);
        check_value("os_weight_down", WeightDown, 1);
        EN = 1'b1; Input = 8'sd1; WeightIn = 8'sd1; step();
        FLUSH = 1'b1; step();
        check_value("os_acc_cleared", PsumOut, 1);
        step();
        check_value("os_hold", PsumOut, 1);
        DRAIN = 1'b1; PsumIn = 32'sd11; step();
        check_value("os_drain", PsumOut, 11);
        EN = 1'b1; Input = 8'sd2; WeightIn = 8'sd2; step();
        FLUSH = 1'b1; DRAIN = 1'b1; PsumIn = 32'sd99; step();
        check_value("os_flush_prio", PsumOut, 4);
        LOAD = 1'b1; WeightIn = 8'sd50; step();
        check_value("os_load_ignored", WeightDown, 2);
        step();

        check_value("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
